// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the ALU issue/writeback controller:
//   - opcode constants (ALU ops 0000..1011, LOADI 1111, 1100..1110 illegal)
//   - controller FSM state encoding
//   - bit positions of the fields inside the 18-bit instruction word
//     {op[17:14], rd[13:12], ra[11:10], rb[9:8], imm[7:0]}
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

   localparam int INSTR_W = 18;

   // Instruction field positions (LSB of each field)
   localparam int OP_LSB  = 14;
   localparam int RD_LSB  = 12;
   localparam int RA_LSB  = 10;
   localparam int RB_LSB  = 8;
   localparam int IMM_LSB = 0;

   // ALU opcodes; the value is passed to the ALU select unchanged
   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_OR    = 4'b0011;
   localparam logic [3:0] OP_XOR   = 4'b0100;
   localparam logic [3:0] OP_NOT   = 4'b0101;
   localparam logic [3:0] OP_SHL   = 4'b0110;
   localparam logic [3:0] OP_SHR   = 4'b0111;
   localparam logic [3:0] OP_ROL   = 4'b1000;
   localparam logic [3:0] OP_ROR   = 4'b1001;
   localparam logic [3:0] OP_EQ    = 4'b1010;
   localparam logic [3:0] OP_LT    = 4'b1011;
   localparam logic [3:0] OP_LOADI = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // True for opcodes that go through the external ALU
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op <= OP_LT);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// -----------------------------------------------------------------------------
// alu_regfile
// Small register file for the issue controller.
//   clk, rst_n            : clock, asynchronous active-low clear of all entries
//   i_raddr_a/o_rdata_a   : combinational read port A
//   i_raddr_b/o_rdata_b   : combinational read port B
//   i_we/i_waddr/i_wdata  : synchronous write port
// Reads return the contents before a write on the same edge.
// -----------------------------------------------------------------------------
module alu_regfile
   import alu_issue_ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [REG_AW-1:0] i_raddr_a,
   input  logic [REG_AW-1:0] i_raddr_b,
   output logic [DATA_W-1:0] o_rdata_a,
   output logic [DATA_W-1:0] o_rdata_b
);

   localparam int DEPTH = 1 << REG_AW;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Serial issue/writeback controller sitting in front of an external
// combinational ALU. One instruction in flight at a time.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_instr_valid/o_instr_ready : instruction handshake, i_instr = 18-bit word
//   o_alu_a/o_alu_b/o_alu_sel   : registered ALU operand/select drive
//   i_alu_c                     : ALU result (combinational from the above)
//   o_res_valid/i_res_ready     : result handshake
//   o_res_data/o_res_rd/o_res_err : result value, destination, illegal-op flag
//   o_op_count                  : completed instructions (wraps at 16 bits)
// -----------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int REG_AW = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_instr_valid,
   output logic               o_instr_ready,
   input  logic [INSTR_W-1:0] i_instr,
   output logic [DATA_W-1:0]  o_alu_a,
   output logic [DATA_W-1:0]  o_alu_b,
   output logic [3:0]         o_alu_sel,
   input  logic [DATA_W-1:0]  i_alu_c,
   output logic               o_res_valid,
   input  logic               i_res_ready,
   output logic [DATA_W-1:0]  o_res_data,
   output logic [REG_AW-1:0]  o_res_rd,
   output logic               o_res_err,
   output logic [15:0]        o_op_count
);

   state_e            r_state;
   state_e            w_state_next;

   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [3:0]        r_alu_sel;
   logic [DATA_W-1:0] r_res_data;
   logic [REG_AW-1:0] r_res_rd;
   logic              r_res_err;
   logic [15:0]       r_op_count;

   logic [3:0]        w_op;
   logic [REG_AW-1:0] w_rd;
   logic [REG_AW-1:0] w_ra;
   logic [REG_AW-1:0] w_rb;
   logic [DATA_W-1:0] w_imm;
   logic              w_accept;
   logic              w_is_alu;
   logic [DATA_W-1:0] w_rdata_a;
   logic [DATA_W-1:0] w_rdata_b;
   logic              w_we;
   logic [REG_AW-1:0] w_waddr;
   logic [DATA_W-1:0] w_wdata;

   assign w_op  = i_instr[OP_LSB +: 4];
   assign w_rd  = i_instr[RD_LSB +: REG_AW];
   assign w_ra  = i_instr[RA_LSB +: REG_AW];
   assign w_rb  = i_instr[RB_LSB +: REG_AW];
   assign w_imm = i_instr[IMM_LSB +: DATA_W];

   assign w_is_alu      = is_alu_op(w_op);
   assign o_instr_ready = (r_state == ST_IDLE);
   assign w_accept      = i_instr_valid && o_instr_ready;

   alu_regfile #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (w_ra),
      .i_raddr_b (w_rb),
      .o_rdata_a (w_rdata_a),
      .o_rdata_b (w_rdata_b)
   );

   // Next state and the single register-file write port. LOADI writes in
   // its handshake cycle; ALU ops write the ALU result at the end of EXEC,
   // using the destination already latched into r_res_rd.
   always_comb begin
      w_state_next = r_state;
      w_we         = 1'b0;
      w_waddr      = r_res_rd;
      w_wdata      = i_alu_c;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_is_alu) begin
                  w_state_next = ST_EXEC;
               end else begin
                  w_state_next = ST_RESP;
                  if (w_op == OP_LOADI) begin
                     w_we    = 1'b1;
                     w_waddr = w_rd;
                     w_wdata = w_imm;
                  end
               end
            end
         end
         ST_EXEC: begin
            w_we         = 1'b1;
            w_state_next = ST_RESP;
         end
         ST_RESP: begin
            if (i_res_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_alu_a    <= '0;
         r_alu_b    <= '0;
         r_alu_sel  <= '0;
         r_res_data <= '0;
         r_res_rd   <= '0;
         r_res_err  <= 1'b0;
         r_op_count <= '0;
      end else begin
         r_state <= w_state_next;

         if (r_state == ST_IDLE && w_accept) begin
            r_alu_a  <= w_rdata_a;
            r_alu_b  <= w_rdata_b;
            r_res_rd <= w_rd;
            // Non-ALU opcodes park the select at 0 so 1100..1111 never
            // reach the ALU.
            r_alu_sel <= w_is_alu ? w_op : 4'b0000;
            if (w_op == OP_LOADI) begin
               r_res_data <= w_imm;
               r_res_err  <= 1'b0;
            end else if (!w_is_alu) begin
               r_res_data <= '0;
               r_res_err  <= 1'b1;
            end
         end

         if (r_state == ST_EXEC) begin
            r_res_data <= i_alu_c;
            r_res_err  <= 1'b0;
         end

         if (r_state == ST_RESP && i_res_ready) begin
            r_op_count <= r_op_count + 16'd1;
         end
      end
   end

   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_sel   = r_alu_sel;
   assign o_res_valid = (r_state == ST_RESP);
   assign o_res_data  = r_res_data;
   assign o_res_rd    = r_res_rd;
   assign o_res_err   = r_res_err;
   assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl with a behavioural model of the external
// 8-bit ALU. A table of instructions with hand-computed expectations is run
// in order, followed by hand-written multi-cycle sequences: result hold,
// back-to-back issue, and reset during EXEC.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        i_instr_valid;
   logic        o_instr_ready;
   logic [17:0] i_instr;
   logic [7:0]  o_alu_a;
   logic [7:0]  o_alu_b;
   logic [3:0]  o_alu_sel;
   logic [7:0]  i_alu_c;
   logic        o_res_valid;
   logic        i_res_ready;
   logic [7:0]  o_res_data;
   logic [1:0]  o_res_rd;
   logic        o_res_err;
   logic [15:0] o_op_count;

   int total;
   int bad;
   int exp_count;

   alu_issue_ctrl #(
      .DATA_W (8),
      .REG_AW (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_instr_valid (i_instr_valid),
      .o_instr_ready (o_instr_ready),
      .i_instr       (i_instr),
      .o_alu_a       (o_alu_a),
      .o_alu_b       (o_alu_b),
      .o_alu_sel     (o_alu_sel),
      .i_alu_c       (i_alu_c),
      .o_res_valid   (o_res_valid),
      .i_res_ready   (i_res_ready),
      .o_res_data    (o_res_data),
      .o_res_rd      (o_res_rd),
      .o_res_err     (o_res_err),
      .o_op_count    (o_op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the external combinational ALU
   always_comb begin
      i_alu_c = 8'h00;
      case (o_alu_sel)
         4'd0:  i_alu_c = o_alu_a + o_alu_b;
         4'd1:  i_alu_c = o_alu_a - o_alu_b;
         4'd2:  i_alu_c = o_alu_a & o_alu_b;
         4'd3:  i_alu_c = o_alu_a | o_alu_b;
         4'd4:  i_alu_c = o_alu_a ^ o_alu_b;
         4'd5:  i_alu_c = ~o_alu_a;
         4'd6:  i_alu_c = {o_alu_a[6:0], 1'b0};
         4'd7:  i_alu_c = {1'b0, o_alu_a[7:1]};
         4'd8:  i_alu_c = {o_alu_a[6:0], o_alu_a[7]};
         4'd9:  i_alu_c = {o_alu_a[0], o_alu_a[7:1]};
         4'd10: i_alu_c = {7'd0, (o_alu_a == o_alu_b)};
         4'd11: i_alu_c = {7'd0, (o_alu_a < o_alu_b)};
         default: i_alu_c = 8'h00;
      endcase
   end

   typedef struct {
      logic [3:0] op;
      logic [1:0] rd;
      logic [1:0] ra;
      logic [1:0] rb;
      logic [7:0] imm;
      logic [7:0] ea;
      logic [7:0] eb;
      logic [3:0] esel;
      logic [7:0] edata;
      logic       eerr;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] op, input logic [1:0] rd,
                               input logic [1:0] ra, input logic [1:0] rb,
                               input logic [7:0] imm, input logic [7:0] ea,
                               input logic [7:0] eb, input logic [3:0] esel,
                               input logic [7:0] edata, input logic eerr);
      vec_t v;
      v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm;
      v.ea = ea; v.eb = eb; v.esel = esel; v.edata = edata; v.eerr = eerr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one instruction from IDLE, check the ALU drive, latency and result,
   // then accept the result and check the completion count.
   task automatic run(input vec_t v);
      int lat;
      chk("instr_ready_idle", {31'd0, o_instr_ready}, 32'd1);
      i_instr       = {v.op, v.rd, v.ra, v.rb, v.imm};
      i_instr_valid = 1'b1;
      @(posedge clk); #1;
      i_instr_valid = 1'b0;
      chk("alu_a", {24'd0, o_alu_a}, {24'd0, v.ea});
      chk("alu_b", {24'd0, o_alu_b}, {24'd0, v.eb});
      chk("alu_sel", {28'd0, o_alu_sel}, {28'd0, v.esel});
      lat = 1;
      while (!o_res_valid && lat < 6) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", lat, (v.op <= 4'd11) ? 32'd2 : 32'd1);
      chk("res_data", {24'd0, o_res_data}, {24'd0, v.edata});
      chk("res_rd", {30'd0, o_res_rd}, {30'd0, v.rd});
      chk("res_err", {31'd0, o_res_err}, {31'd0, v.eerr});
      i_res_ready = 1'b1;
      @(posedge clk); #1;
      i_res_ready = 1'b0;
      exp_count++;
      chk("op_count", {16'd0, o_op_count}, exp_count);
      chk("res_valid_done", {31'd0, o_res_valid}, 32'd0);
      $display("instr op=%b rd=%0d ra=%0d rb=%0d imm=%02h -> a=%02h b=%02h sel=%0d data=%02h err=%b lat=%0d cnt=%0d",
               v.op, v.rd, v.ra, v.rb, v.imm, o_alu_a, o_alu_b, o_alu_sel,
               o_res_data, o_res_err, lat, o_op_count);
   endtask

   vec_t vecs[15];
   vec_t b2b[4];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int cyc;
      int last;
      logic acc;

      total = 0; bad = 0; exp_count = 0;
      rst_n = 1'b0; i_instr_valid = 1'b0; i_instr = '0; i_res_ready = 1'b0;

      //          op     rd    ra    rb    imm    a      b      sel    data   err
      vecs[0]  = mk(4'hF, 2'd1, 2'd0, 2'd0, 8'h05, 8'h00, 8'h00, 4'h0, 8'h05, 1'b0);
      vecs[1]  = mk(4'hF, 2'd2, 2'd0, 2'd0, 8'h03, 8'h00, 8'h00, 4'h0, 8'h03, 1'b0);
      vecs[2]  = mk(4'h0, 2'd0, 2'd1, 2'd2, 8'h00, 8'h05, 8'h03, 4'h0, 8'h08, 1'b0);
      vecs[3]  = mk(4'hF, 2'd1, 2'd0, 2'd0, 8'hF0, 8'h08, 8'h08, 4'h0, 8'hF0, 1'b0);
      vecs[4]  = mk(4'hF, 2'd2, 2'd0, 2'd0, 8'h20, 8'h08, 8'h08, 4'h0, 8'h20, 1'b0);
      vecs[5]  = mk(4'h0, 2'd3, 2'd1, 2'd2, 8'h00, 8'hF0, 8'h20, 4'h0, 8'h10, 1'b0);
      vecs[6]  = mk(4'h1, 2'd3, 2'd2, 2'd1, 8'h00, 8'h20, 8'hF0, 4'h1, 8'h30, 1'b0);
      vecs[7]  = mk(4'hB, 2'd3, 2'd2, 2'd1, 8'h00, 8'h20, 8'hF0, 4'hB, 8'h01, 1'b0);
      vecs[8]  = mk(4'hD, 2'd1, 2'd1, 2'd2, 8'h5A, 8'hF0, 8'h20, 4'h0, 8'h00, 1'b1);
      vecs[9]  = mk(4'h3, 2'd1, 2'd1, 2'd1, 8'h00, 8'hF0, 8'hF0, 4'h3, 8'hF0, 1'b0);
      vecs[10] = mk(4'h0, 2'd2, 2'd2, 2'd2, 8'h00, 8'h20, 8'h20, 4'h0, 8'h40, 1'b0);
      vecs[11] = mk(4'h4, 2'd0, 2'd0, 2'd2, 8'h00, 8'h08, 8'h40, 4'h4, 8'h48, 1'b0);
      vecs[12] = mk(4'hA, 2'd3, 2'd0, 2'd0, 8'h00, 8'h48, 8'h48, 4'hA, 8'h01, 1'b0);
      vecs[13] = mk(4'hE, 2'd0, 2'd3, 2'd0, 8'h00, 8'h01, 8'h48, 4'h0, 8'h00, 1'b1);
      vecs[14] = mk(4'hC, 2'd2, 2'd2, 2'd2, 8'h00, 8'h40, 8'h40, 4'h0, 8'h00, 1'b1);

      // Back-to-back ALU ops on r0 (r1=F0, r2=40, r3=AA when they run)
      b2b[0] = mk(4'h0, 2'd0, 2'd2, 2'd2, 8'h00, 8'h00, 8'h00, 4'h0, 8'h80, 1'b0);
      b2b[1] = mk(4'h0, 2'd0, 2'd0, 2'd2, 8'h00, 8'h00, 8'h00, 4'h0, 8'hC0, 1'b0);
      b2b[2] = mk(4'h1, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 4'h1, 8'hD0, 1'b0);
      b2b[3] = mk(4'h4, 2'd0, 2'd0, 2'd3, 8'h00, 8'h00, 8'h00, 4'h4, 8'h7A, 1'b0);

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_instr_ready", {31'd0, o_instr_ready}, 32'd1);
      chk("rst_res_valid", {31'd0, o_res_valid}, 32'd0);
      chk("rst_res_data", {24'd0, o_res_data}, 32'd0);
      chk("rst_res_err", {31'd0, o_res_err}, 32'd0);
      chk("rst_op_count", {16'd0, o_op_count}, 32'd0);
      chk("rst_alu_sel", {28'd0, o_alu_sel}, 32'd0);
      chk("rst_alu_a", {24'd0, o_alu_a}, 32'd0);

      // ---------------- table-driven vectors ----------------
      for (int i = 0; i < 15; i++) begin
         run(vecs[i]);
      end

      // ---------------- result held under backpressure ----------------
      i_instr       = {4'hF, 2'd3, 2'd0, 2'd0, 8'hAA};
      i_instr_valid = 1'b1;
      @(posedge clk); #1;
      i_instr = {4'hF, 2'd2, 2'd0, 2'd0, 8'h55};   // must not be accepted
      for (int k = 0; k < 5; k++) begin
         chk("hold_instr_ready", {31'd0, o_instr_ready}, 32'd0);
         chk("hold_res_valid", {31'd0, o_res_valid}, 32'd1);
         chk("hold_res_data", {24'd0, o_res_data}, 32'h000000AA);
         chk("hold_res_rd", {30'd0, o_res_rd}, 32'd3);
         @(posedge clk); #1;
      end
      i_instr_valid = 1'b0;
      i_res_ready   = 1'b1;
      @(posedge clk); #1;
      i_res_ready = 1'b0;
      exp_count++;
      chk("hold_op_count", {16'd0, o_op_count}, exp_count);
      chk("hold_release_ready", {31'd0, o_instr_ready}, 32'd1);
      $display("hold sequence: LOADI r3=AA held 5 cycles, cnt=%0d", o_op_count);
      // r2 must still hold 40: the offered LOADI r2=55 was never taken
      run(mk(4'h3, 2'd2, 2'd2, 2'd2, 8'h00, 8'h40, 8'h40, 4'h3, 8'h40, 1'b0));

      // ---------------- back-to-back issue ----------------
      n = 0; cyc = 0; last = 0;
      i_res_ready   = 1'b1;
      i_instr       = {b2b[0].op, b2b[0].rd, b2b[0].ra, b2b[0].rb, b2b[0].imm};
      i_instr_valid = 1'b1;
      while (n < 4 && cyc < 40) begin
         acc = o_instr_ready;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            if (n > 0) chk("b2b_interval", cyc - last, 32'd3);
            $display("b2b accept %0d at cycle %0d", n, cyc);
            last = cyc;
            n++;
            if (n < 4) i_instr = {b2b[n].op, b2b[n].rd, b2b[n].ra, b2b[n].rb, b2b[n].imm};
         end
      end
      i_instr_valid = 1'b0;
      chk("b2b_accepts", n, 32'd4);
      repeat (2) @(posedge clk);
      #1;
      i_res_ready = 1'b0;
      exp_count += 4;
      chk("b2b_op_count", {16'd0, o_op_count}, exp_count);
      chk("b2b_last_data", {24'd0, o_res_data}, 32'h0000007A);
      chk("b2b_idle", {31'd0, o_instr_ready}, 32'd1);
      $display("b2b done: data=%02h cnt=%0d", o_res_data, o_op_count);

      // ---------------- reset during EXEC ----------------
      i_instr       = {4'h0, 2'd2, 2'd1, 2'd1, 8'h00};   // ADD r2 = r1 + r1
      i_instr_valid = 1'b1;
      @(posedge clk); #1;
      i_instr_valid = 1'b0;
      chk("exec_alu_a", {24'd0, o_alu_a}, 32'h000000F0);
      rst_n = 1'b0;
      #1;
      exp_count = 0;
      chk("midrst_res_valid", {31'd0, o_res_valid}, 32'd0);
      chk("midrst_op_count", {16'd0, o_op_count}, 32'd0);
      chk("midrst_instr_ready", {31'd0, o_instr_ready}, 32'd1);
      chk("midrst_alu_a", {24'd0, o_alu_a}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      $display("reset during EXEC applied and released");
      run(mk(4'h3, 2'd2, 2'd2, 2'd2, 8'h00, 8'h00, 8'h00, 4'h3, 8'h00, 1'b0));
      run(mk(4'h3, 2'd1, 2'd1, 2'd1, 8'h00, 8'h00, 8'h00, 4'h3, 8'h00, 1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
